// File: rtl/light_level_ctrl.sv
// light_level_ctrl: paces SPI light-sensor conversions, captures each frame's
// 8-bit sample, block-averages it, and drives the lamp with hysteresis + PWM.
// Optional feature macro: LIGHT_LEVEL_CTRL_MANUAL_EN adds manualEn/manualDuty
// ports that override the lamp duty while keeping sampling alive.
`timescale 1ns/1ps
module light_level_ctrl #(
    parameter int unsigned SAMPLE_PERIOD = 1000000,
    parameter int unsigned AVG_LOG2      = 3,
    parameter logic [7:0]  THRESH_LO     = 8'd96,
    parameter logic [7:0]  THRESH_HI     = 8'd160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SS,
    input  logic [15:0] wordReg,
`ifdef LIGHT_LEVEL_CTRL_MANUAL_EN
    input  logic        manualEn,
    input  logic [7:0]  manualDuty,
`endif
    output logic        start,
    output logic [7:0]  sample,
    output logic [7:0]  avg,
    output logic        avgValid,
    output logic        lampOn,
    output logic        pwmOut,
    output logic        overrun
);

    localparam int unsigned PW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned AW = 8 + AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_LOW,
        WAIT_HIGH,
        CAPTURE
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [PW-1:0]       periodCnt;
    logic                tick;
    logic [3:0]          tmoCnt;
    logic                ssD;
    logic [7:0]          newSample;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       accSum;
    logic [AVG_LOG2-1:0] n;
    logic                hyst;
    logic [7:0]          target;
    logic [7:0]          duty;
    logic [7:0]          pwmCnt;
    logic                unusedWordBits;

    assign tick           = (periodCnt == PW'(SAMPLE_PERIOD - 1));
    assign newSample      = wordReg[12:5];
    assign accSum         = acc + AW'(newSample);
    assign unusedWordBits = ^{wordReg[15:13], wordReg[4:0]};
    assign pwmOut         = (pwmCnt < duty);

    // Conversion pacing counter; tick marks the wrap cycle.
    always_ff @(posedge clk) begin
        if (reset || tick) periodCnt <= '0;
        else               periodCnt <= periodCnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // FSM next-state and start pulse.
    always_comb begin
        stateNext = state;
        start     = 1'b0;
        case (state)
            IDLE:      if (tick) stateNext = ARM;
            ARM: begin
                start     = 1'b1;
                stateNext = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!SS)                  stateNext = WAIT_HIGH;
                else if (tmoCnt == 4'd15) stateNext = IDLE;
            end
            WAIT_HIGH: if (SS && !ssD) stateNext = CAPTURE;
            CAPTURE:   stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // WAIT_LOW timeout counter and SS edge-detect register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmoCnt <= '0;
            ssD    <= 1'b1;
        end else begin
            tmoCnt <= (state == WAIT_LOW) ? tmoCnt + 1'b1 : '0;
            ssD    <= SS;
        end
    end

    // Sticky overrun: a period tick while a conversion is still outstanding.
    always_ff @(posedge clk) begin
        if (reset)                       overrun <= 1'b0;
        else if (tick && state != IDLE)  overrun <= 1'b1;
    end

    // Sample capture and block averaging; the last sample of a block folds
    // straight into the average so acc never needs an extra bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample   <= '0;
            acc      <= '0;
            n        <= '0;
            avg      <= '0;
            avgValid <= 1'b0;
        end else begin
            avgValid <= 1'b0;
            if (state == CAPTURE) begin
                sample <= newSample;
                if (n == '1) begin
                    avg      <= accSum[AW-1:AVG_LOG2];
                    acc      <= '0;
                    n        <= '0;
                    avgValid <= 1'b1;
                end else begin
                    acc <= accSum;
                    n   <= n + 1'b1;
                end
            end
        end
    end

    // Hysteresis on each new average; frozen while manual override is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            hyst <= 1'b0;
`ifdef LIGHT_LEVEL_CTRL_MANUAL_EN
        end else if (avgValid && !manualEn) begin
`else
        end else if (avgValid) begin
`endif
            if (avg < THRESH_LO)      hyst <= 1'b1;
            else if (avg > THRESH_HI) hyst <= 1'b0;
        end
    end

    // Lamp enable and duty target selection.
    always_comb begin
        lampOn = hyst;
        target = hyst ? (8'd255 - avg) : '0;
`ifdef LIGHT_LEVEL_CTRL_MANUAL_EN
        if (manualEn) begin
            lampOn = (manualDuty != '0);
            target = manualDuty;
        end
`endif
    end

    // Free-running PWM; duty reloads only at the wrap to avoid glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwmCnt <= '0;
            duty   <= '0;
        end else begin
            pwmCnt <= pwmCnt + 1'b1;
            if (pwmCnt == 8'hFF) duty <= target;
        end
    end

endmodule

// File: tb/tb_light_level_ctrl.sv
// tb_light_level_ctrl: randomized SPI-frame stimulus checked against a
// block-average / hysteresis reference model kept in the bench.
`timescale 1ns/1ps
module tb_light_level_ctrl;

    localparam int unsigned PERIOD = 200;
    localparam int unsigned LOG2   = 2;
    localparam int unsigned BLK    = 1 << LOG2;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        SS         = 1'b1;
    logic [15:0] wordReg    = '0;
    logic        manualEn   = 1'b0;
    logic [7:0]  manualDuty = '0;
    logic        start;
    logic [7:0]  sample;
    logic [7:0]  avg;
    logic        avgValid;
    logic        lampOn;
    logic        pwmOut;
    logic        overrun;

    int unsigned nCompared   = 0;
    int unsigned nMismatched = 0;

    // Reference model state
    int unsigned blkQ[$];
    int unsigned refSample = 0;
    int unsigned refAvg    = 0;
    bit          refLamp   = 1'b0;

    always #5 clk = ~clk;

    light_level_ctrl #(
        .SAMPLE_PERIOD(PERIOD),
        .AVG_LOG2     (LOG2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SS        (SS),
        .wordReg   (wordReg),
`ifdef LIGHT_LEVEL_CTRL_MANUAL_EN
        .manualEn  (manualEn),
        .manualDuty(manualDuty),
`endif
        .start     (start),
        .sample    (sample),
        .avg       (avg),
        .avgValid  (avgValid),
        .lampOn    (lampOn),
        .pwmOut    (pwmOut),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Model: collect samples into blocks, average by floor division, apply hysteresis.
    task automatic ref_capture(input int unsigned s, output bit done);
        int unsigned sum;
        sum       = 0;
        done      = 1'b0;
        refSample = s;
        blkQ.push_back(s);
        if (blkQ.size() == BLK) begin
            foreach (blkQ[i]) sum += blkQ[i];
            refAvg = sum / BLK;
            blkQ.delete();
            done = 1'b1;
            if (!manualEn) begin
                if (refAvg < 96)       refLamp = 1'b1;
                else if (refAvg > 160) refLamp = 1'b0;
            end
        end
    endtask

    function automatic int unsigned ref_lamp();
        if (manualEn) return (manualDuty != 0) ? 1 : 0;
        return refLamp ? 1 : 0;
    endfunction

    function automatic int unsigned ref_duty();
        if (manualEn) return manualDuty;
        return refLamp ? 255 - refAvg : 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        SS    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start",    start,    0);
        check("rst_sample",   sample,   0);
        check("rst_avg",      avg,      0);
        check("rst_avgValid", avgValid, 0);
        check("rst_lampOn",   lampOn,   0);
        check("rst_pwmOut",   pwmOut,   0);
        check("rst_overrun",  overrun,  0);
        blkQ.delete();
        refSample = 0;
        refAvg    = 0;
        refLamp   = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 450 && !ok; i++) begin
            @(negedge clk);
            if (start) ok = 1'b1;
        end
        check("start_seen", ok, 1);
    endtask

    // SPI slave model: answer a start with an SS low pulse and a frame carrying s.
    task automatic serve(input logic [7:0] s, input int unsigned d, input int unsigned lowLen,
                         output int unsigned extra);
        bit          ok;
        bit          done;
        logic [15:0] w;
        extra = 0;
        wait_start(ok);
        if (!ok) return;
        repeat (d) @(negedge clk);
        SS      = 1'b0;
        wordReg = 16'($urandom);
        repeat (lowLen) begin
            @(negedge clk);
            if (start) extra++;
        end
        w       = 16'($urandom);
        w[12:5] = s;
        wordReg = w;
        SS      = 1'b1;
        repeat (2) @(negedge clk);
        ref_capture(s, done);
        check("sample",   sample,   refSample);
        check("avgValid", avgValid, done);
        if (done) check("avg", avg, refAvg);
        @(negedge clk);
        check("avgValid_width", avgValid, 0);
        check("lampOn",         lampOn,   ref_lamp());
    endtask

    task automatic serve_rand(input logic [7:0] s);
        int unsigned extra;
        serve(s, $urandom_range(0, 12), $urandom_range(1, 40), extra);
    endtask

    task automatic measure_duty(input string tag);
        int unsigned hi;
        hi = 0;
        repeat (260) @(negedge clk);
        repeat (256) begin
            @(negedge clk);
            hi += 32'(pwmOut);
        end
        check(tag, hi, ref_duty());
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pulses, first, second, run, maxRun, nValid, extra;
        pulses = 0; first = 0; second = 0; run = 0; maxRun = 0; nValid = 0; extra = 0;

        // Idle sensor: start pacing and timeouts
        do_reset();
        for (int unsigned i = 1; i <= 450; i++) begin
            @(negedge clk);
            if (start) begin
                run++;
                if (run == 1) begin
                    pulses++;
                    if (pulses == 1)      first  = i - 1;
                    else if (pulses == 2) second = i - 1;
                end
            end else begin
                run = 0;
            end
            if (run > maxRun) maxRun = run;
            if (avgValid) nValid++;
        end
        check("s1_pulses",  pulses,  2);
        check("s1_first",   first,   199);
        check("s1_second",  second,  399);
        check("s1_width",   maxRun,  1);
        check("s1_avgv",    nValid,  0);
        check("s1_overrun", overrun, 0);
        check("s1_sample",  sample,  0);

        // Dark room: sample 80 x4
        repeat (4) serve_rand(8'd80);
        check("s2_avg", avg, 80);
        measure_duty("s2_duty");

        // Bright: truncating average 200
        serve_rand(8'd200);
        serve_rand(8'd200);
        serve_rand(8'd200);
        serve_rand(8'd201);
        check("s3_avg", avg, 200);
        measure_duty("s3_duty");

        // Threshold boundaries
        repeat (4) serve_rand(8'd160);
        repeat (4) serve_rand(8'd96);
        repeat (4) serve_rand(8'd95);
        measure_duty("s4_duty");
        repeat (4) serve_rand(8'd160);
        repeat (4) serve_rand(8'd161);

        // Long frame: overrun without extra start
        check("s5_overrun_pre", overrun, 0);
        serve(8'($urandom), 2, 300, extra);
        check("s5_extra_start", extra,   0);
        check("s5_overrun",     overrun, 1);
        repeat (3) serve_rand(8'($urandom));

        // Random frames
        for (int unsigned b = 0; b < 5 * BLK; b++) serve_rand(8'($urandom));
        measure_duty("rand_duty");

        // Reset part-way through a block
        serve_rand(8'($urandom));
        serve_rand(8'($urandom));
        do_reset();
        repeat (4) serve_rand(8'd40);
        check("s6_avg",     avg,     40);
        check("s6_overrun", overrun, 0);
        measure_duty("s6_duty");

`ifdef LIGHT_LEVEL_CTRL_MANUAL_EN
        @(negedge clk);
        manualEn   = 1'b1;
        manualDuty = 8'd64;
        @(negedge clk);
        check("man_lamp", lampOn, 1);
        repeat (4) serve_rand(8'd200);
        measure_duty("man_duty");
        manualDuty = 8'd0;
        @(negedge clk);
        check("man_lamp_zero", lampOn, 0);
        manualEn = 1'b0;
        @(negedge clk);
        check("man_lamp_resume", lampOn, ref_lamp());
        measure_duty("man_resume_duty");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
